// File: rtl/adc_sample_sequencer_pkg.sv
// rtl/adc_sample_sequencer_pkg.sv - shared state encoding and default parameters for the ADC sequencer
package adc_sample_sequencer_pkg;

    localparam int DEFAULT_FIFO_DEPTH     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CONVERT = 2'd2,
        ST_RECOVER = 2'd3
    } seq_state_t;

endpackage

// File: rtl/adc_result_fifo.sv
// rtl/adc_result_fifo.sv - first-word-fall-through result FIFO with overflow-safe push gating
module adc_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - ADC start/capture sequencer with pacing, timeout and result FIFO
module adc_sample_sequencer
    import adc_sample_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        enable_in,
    input  logic                        single_shot_in,
    input  logic [15:0]                 period_in,
    input  logic [15:0]                 cfg_1_in,
    input  logic [15:0]                 cfg_2_in,
    output logic                        start_conversion_out,
    output logic [15:0]                 config_1_out,
    output logic [15:0]                 config_2_out,
    input  logic [15:0]                 result_in,
    input  logic                        conversion_finished_in,
    input  logic                        rd_en_in,
    output logic [15:0]                 rd_data_out,
    output logic                        rd_valid_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_out,
    output logic                        overflow_out,
    output logic                        timeout_out,
    input  logic                        clear_flags_in,
    output logic                        busy_out
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t  state;
    seq_state_t  next_state;
    logic        fin_meta;
    logic        fin_s;
    logic        single_mode;
    logic [15:0] period_cnt;
    logic [TW-1:0] timeout_cnt;
    logic        start_conv;
    logic        capture;
    logic        set_timeout;
    logic        period_ok;
    logic        timeout_hit;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow_hit;

    // Counters read zero on the edge a conversion starts, so "+1" gives cycles elapsed since that edge.
    assign period_ok   = ({1'b0, period_cnt} + 17'd1) >= {1'b0, period_in};
    assign timeout_hit = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        next_state  = state;
        start_conv  = 1'b0;
        capture     = 1'b0;
        set_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable_in || single_shot_in) begin
                    next_state = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!single_mode && !enable_in) begin
                    next_state = ST_IDLE;
                end else if (!fin_s && period_ok) begin
                    next_state = ST_CONVERT;
                    start_conv = 1'b1;
                end
            end
            ST_CONVERT: begin
                if (fin_s) begin
                    capture    = 1'b1;
                    next_state = ST_RECOVER;
                end else if (timeout_hit) begin
                    set_timeout = 1'b1;
                    next_state  = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (!fin_s) begin
                    next_state = (enable_in && !single_mode) ? ST_ARM : ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign overflow_hit = capture && fifo_full && !(rd_en_in && !fifo_empty);
    assign busy_out     = (state != ST_IDLE);
    assign rd_valid_out = !fifo_empty;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state                <= ST_IDLE;
            fin_meta             <= 1'b0;
            fin_s                <= 1'b0;
            single_mode          <= 1'b0;
            period_cnt           <= '0;
            timeout_cnt          <= '0;
            start_conversion_out <= 1'b0;
            config_1_out         <= '0;
            config_2_out         <= '0;
            overflow_out         <= 1'b0;
            timeout_out          <= 1'b0;
        end else begin
            state                <= next_state;
            fin_meta             <= conversion_finished_in;
            fin_s                <= fin_meta;
            start_conversion_out <= (next_state == ST_CONVERT);
            if (state == ST_IDLE && next_state == ST_ARM) begin
                single_mode <= !enable_in;
            end
            if (start_conv) begin
                period_cnt   <= '0;
                timeout_cnt  <= '0;
                config_1_out <= cfg_1_in;
                config_2_out <= cfg_2_in;
            end else begin
                if (period_cnt != 16'hFFFF) begin
                    period_cnt <= period_cnt + 16'd1;
                end
                if (state == ST_CONVERT) begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end
            if (set_timeout) begin
                timeout_out <= 1'b1;
            end else if (clear_flags_in) begin
                timeout_out <= 1'b0;
            end
            if (overflow_hit) begin
                overflow_out <= 1'b1;
            end else if (clear_flags_in) begin
                overflow_out <= 1'b0;
            end
        end
    end

    adc_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push    (capture),
        .pop     (rd_en_in),
        .data    (result_in),
        .rd_data (rd_data_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count_out)
    );

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb/tb_adc_sample_sequencer.sv - directed scoreboard bench for adc_sample_sequencer
module tb_adc_sample_sequencer;
    localparam int FIFO_DEPTH     = 4;
    localparam int TIMEOUT_CYCLES = 1023;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable_in;
    logic        single_shot_in;
    logic [15:0] period_in;
    logic [15:0] cfg_1_in;
    logic [15:0] cfg_2_in;
    logic        start_conversion_out;
    logic [15:0] config_1_out;
    logic [15:0] config_2_out;
    logic [15:0] result_in = 16'h0000;
    logic        conversion_finished_in = 1'b0;
    logic        rd_en_in;
    logic [15:0] rd_data_out;
    logic        rd_valid_out;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_out;
    logic        overflow_out;
    logic        timeout_out;
    logic        clear_flags_in;
    logic        busy_out;

    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    logic [15:0] sb[$];
    logic [15:0] adc_result = 16'h0000;
    bit          adc_hang = 1'b0;
    bit          read_on_capture = 1'b0;
    int          cyc = 0;
    int          start_rises = 0;
    int          last_rise = 0;
    int          high_len = 0;
    int          rise_q[$];
    logic        mon_start_q = 1'b0;

    adc_sample_sequencer #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk                    (clk),
        .nrst                   (nrst),
        .enable_in              (enable_in),
        .single_shot_in         (single_shot_in),
        .period_in              (period_in),
        .cfg_1_in               (cfg_1_in),
        .cfg_2_in               (cfg_2_in),
        .start_conversion_out   (start_conversion_out),
        .config_1_out           (config_1_out),
        .config_2_out           (config_2_out),
        .result_in              (result_in),
        .conversion_finished_in (conversion_finished_in),
        .rd_en_in               (rd_en_in),
        .rd_data_out            (rd_data_out),
        .rd_valid_out           (rd_valid_out),
        .fifo_count_out         (fifo_count_out),
        .overflow_out           (overflow_out),
        .timeout_out            (timeout_out),
        .clear_flags_in         (clear_flags_in),
        .busy_out               (busy_out)
    );

    always #5 clk = ~clk;

    // ADC model: finishes on the 20th cycle of start high, drops finished once start falls.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (start_conversion_out !== 1'b1) begin
                conversion_finished_in = 1'b0;
                cnt = 0;
            end else if (!adc_hang && !conversion_finished_in) begin
                cnt++;
                if (cnt == 20) begin
                    result_in = adc_result;
                    conversion_finished_in = 1'b1;
                    if (sb.size() < FIFO_DEPTH || read_on_capture) sb.push_back(adc_result);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (start_conversion_out === 1'b1 && mon_start_q !== 1'b1) begin
                start_rises++;
                last_rise = cyc;
                rise_q.push_back(cyc);
            end else if (start_conversion_out !== 1'b1 && mon_start_q === 1'b1) begin
                high_len = cyc - last_rise;
            end
            mon_start_q = start_conversion_out;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        for (int i = 0; i < limit && busy_out === 1'b1; i++) tick(1);
        check(tag, busy_out, 1'b0);
    endtask

    task automatic wait_fin(input string tag);
        for (int i = 0; i < 100 && conversion_finished_in !== 1'b1; i++) tick(1);
        check(tag, conversion_finished_in, 1'b1);
    endtask

    task automatic read_one(input string tag);
        logic [15:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        check({tag, "_valid"}, rd_valid_out, 1'b1);
        check({tag, "_data"}, rd_data_out, exp);
        rd_en_in = 1'b1;
        tick(1);
        rd_en_in = 1'b0;
    endtask

    task automatic single_shot(input logic [15:0] res);
        adc_result = res;
        single_shot_in = 1'b1;
        tick(1);
        single_shot_in = 1'b0;
        wait_idle(1200, "ss_seq_idle");
    endtask

    initial begin
        logic [15:0] exp;
        nrst = 1'b0;
        enable_in = 1'b0;
        single_shot_in = 1'b0;
        period_in = 16'd0;
        cfg_1_in = 16'h0000;
        cfg_2_in = 16'h0000;
        rd_en_in = 1'b0;
        clear_flags_in = 1'b0;
        tick(3);
        check("rst_start", start_conversion_out, 1'b0);
        check("rst_cfg1", config_1_out, 16'h0000);
        check("rst_cfg2", config_2_out, 16'h0000);
        check("rst_valid", rd_valid_out, 1'b0);
        check("rst_count", fifo_count_out, 0);
        check("rst_rd_data", rd_data_out, 16'h0000);
        check("rst_overflow", overflow_out, 1'b0);
        check("rst_timeout", timeout_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        nrst = 1'b1;
        tick(2);
        check("idle_busy", busy_out, 1'b0);

        // single shot with 3-edge capture latency and config hold
        cfg_1_in = 16'h1357;
        cfg_2_in = 16'h2468;
        adc_result = 16'hA5A5;
        start_rises = 0;
        single_shot_in = 1'b1;
        tick(1);
        single_shot_in = 1'b0;
        check("ss_busy", busy_out, 1'b1);
        wait_fin("ss_fin_seen");
        check("ss_start_high", start_conversion_out, 1'b1);
        check("ss_cfg1", config_1_out, 16'h1357);
        check("ss_cfg2", config_2_out, 16'h2468);
        cfg_1_in = 16'hFFFF;
        check("ss_valid_e1", rd_valid_out, 1'b0);
        tick(1);
        check("ss_valid_e2", rd_valid_out, 1'b0);
        tick(1);
        check("ss_valid_e3", rd_valid_out, 1'b1);
        check("ss_cfg1_hold", config_1_out, 16'h1357);
        wait_idle(200, "ss_idle");
        check("ss_one_start", start_rises, 1);
        check("ss_count", fifo_count_out, 1);
        read_one("ss_read");
        check("ss_count_after", fifo_count_out, 0);
        check("ss_data_hold", rd_data_out, 16'hA5A5);

        // continuous sampling paced at 100 cycles
        period_in = 16'd100;
        adc_result = 16'h1234;
        rise_q.delete();
        start_rises = 0;
        enable_in = 1'b1;
        for (int i = 0; i < 400 && rise_q.size() < 3; i++) tick(1);
        enable_in = 1'b0;
        check("per_starts_seen", rise_q.size(), 3);
        check("per_gap1", (rise_q.size() >= 3) ? rise_q[1] - rise_q[0] : -1, 100);
        check("per_gap2", (rise_q.size() >= 3) ? rise_q[2] - rise_q[1] : -1, 100);
        wait_idle(200, "per_idle");
        check("per_start_total", start_rises, 3);
        check("per_count", fifo_count_out, 3);
        for (int i = 0; i < 3; i++) read_one("per_read");

        // ADC that never finishes
        adc_hang = 1'b1;
        period_in = 16'd0;
        start_rises = 0;
        high_len = 0;
        single_shot_in = 1'b1;
        tick(1);
        single_shot_in = 1'b0;
        wait_idle(1200, "to_idle");
        check("to_high_len", high_len, TIMEOUT_CYCLES);
        check("to_flag", timeout_out, 1'b1);
        check("to_count", fifo_count_out, 0);
        check("to_start_low", start_conversion_out, 1'b0);
        clear_flags_in = 1'b1;
        tick(1);
        clear_flags_in = 1'b0;
        check("to_cleared", timeout_out, 1'b0);
        adc_hang = 1'b0;

        // overflow on the fifth unread result
        for (int i = 1; i <= 5; i++) single_shot(16'(i));
        check("ovf_count", fifo_count_out, FIFO_DEPTH);
        check("ovf_flag", overflow_out, 1'b1);
        for (int i = 0; i < FIFO_DEPTH; i++) read_one("ovf_read");
        check("ovf_drained", fifo_count_out, 0);
        rd_en_in = 1'b1;
        tick(1);
        rd_en_in = 1'b0;
        check("empty_rd_count", fifo_count_out, 0);
        check("empty_rd_hold", rd_data_out, 16'h0004);
        check("empty_rd_valid", rd_valid_out, 1'b0);
        clear_flags_in = 1'b1;
        tick(1);
        clear_flags_in = 1'b0;
        check("ovf_cleared", overflow_out, 1'b0);

        // full FIFO with a read on the capture edge
        for (int i = 6; i <= 9; i++) single_shot(16'(i));
        check("full_count", fifo_count_out, FIFO_DEPTH);
        read_on_capture = 1'b1;
        adc_result = 16'd10;
        single_shot_in = 1'b1;
        tick(1);
        single_shot_in = 1'b0;
        wait_fin("cap_fin_seen");
        tick(1);
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        check("cap_rd_data", rd_data_out, exp);
        rd_en_in = 1'b1;
        tick(1);
        rd_en_in = 1'b0;
        read_on_capture = 1'b0;
        check("cap_count", fifo_count_out, FIFO_DEPTH);
        check("cap_no_ovf", overflow_out, 1'b0);
        wait_idle(200, "cap_idle");
        for (int i = 0; i < FIFO_DEPTH; i++) read_one("cap_read");

        // reset during a conversion, then resume with enable held
        single_shot(16'h0011);
        single_shot(16'h0022);
        check("mid_count", fifo_count_out, 2);
        period_in = 16'd10;
        adc_result = 16'h3C3C;
        enable_in = 1'b1;
        for (int i = 0; i < 100 && start_conversion_out !== 1'b1; i++) tick(1);
        check("mid_started", start_conversion_out, 1'b1);
        tick(2);
        nrst = 1'b0;
        tick(1);
        check("mid_rst_start", start_conversion_out, 1'b0);
        check("mid_rst_count", fifo_count_out, 0);
        check("mid_rst_valid", rd_valid_out, 1'b0);
        check("mid_rst_busy", busy_out, 1'b0);
        check("mid_rst_data", rd_data_out, 16'h0000);
        sb.delete();
        nrst = 1'b1;
        for (int i = 0; i < 300 && rd_valid_out !== 1'b1; i++) tick(1);
        read_one("resume");
        enable_in = 1'b0;
        wait_idle(300, "resume_idle");
        for (int i = 0; i < FIFO_DEPTH && rd_valid_out === 1'b1; i++) read_one("resume_drain");
        check("resume_final_count", fifo_count_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
